// File: rtl/rf_pkg.sv
// Shared types, default sizes and address helpers for the multi-port register file.
package rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Address width for an n-entry file; never narrower than one bit.
    function automatic int rf_addr_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // True when address a names a real entry of an n-entry file.
    function automatic logic rf_in_range(input logic [31:0] a, input int n);
        return (a < 32'(n));
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-writeback bits: one per register, set by issue, cleared by writeback.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int AW     = rf_addr_w(NREGS),
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic                set_busy,
    input  logic [AW-1:0]       set_addr,
    input  logic [NREAD*AW-1:0] raddr,
    output logic [NREAD-1:0]    rbusy
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nx_s;

    // Next busy vector: a writeback clears its entry, a set marks it, and set wins a tie.
    always_comb begin
        busy_nx_s = busy_r;
        if (en) begin
            for (int i = 1; i < NREGS; i++) begin
                if (set_busy && (set_addr == AW'(i))) begin
                    busy_nx_s[i] = 1'b1;
                end else if (we && (waddr == AW'(i))) begin
                    busy_nx_s[i] = 1'b0;
                end else begin
                    busy_nx_s[i] = busy_r[i];
                end
            end
        end else begin
            busy_nx_s = busy_r;
        end
        busy_nx_s[0] = 1'b0;
    end

    // Busy vector register; every entry drops on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nx_s;
        end
    end

    // Per-port lookup; a same-cycle writeback hides the flag when data is bypassed.
    always_comb begin
        rbusy = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (en && rf_in_range(32'(raddr[p*AW +: AW]), NREGS)) begin
                if ((BYPASS != 0) && we && (waddr == raddr[p*AW +: AW])) begin
                    rbusy[p] = 1'b0;
                end else begin
                    rbusy[p] = busy_r[raddr[p*AW +: AW]];
                end
            end else begin
                rbusy[p] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with bypass, scoreboard and a post-reset clear engine.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    parameter int AW     = rf_addr_w(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  set_busy,
    input  logic [AW-1:0]         set_addr
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_t        state_r;
    rf_state_t        state_nx_s;
    logic [AW-1:0]    clr_idx_r;
    logic             ready_r;
    logic             run_s;
    logic             clr_s;
    logic             wr_ok_s;
    logic             mem_we_s;
    logic [AW-1:0]    mem_waddr_s;
    logic [XLEN-1:0]  mem_wdata_s;
    // Storage carries no reset so it can map onto a RAM macro; the clear engine zeroes it.
    logic [XLEN-1:0]  mem_r [NREGS];

    // State register, clear pointer and registered ready flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= CLEAR;
            clr_idx_r <= '0;
            ready_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ready_r <= (state_nx_s == RUN);
            if (clr_s) begin
                clr_idx_r <= clr_idx_r + AW'(1);
            end else begin
                clr_idx_r <= clr_idx_r;
            end
        end
    end

    // Next state: leave CLEAR once the last entry is being zeroed; RUN holds until reset.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            CLEAR: begin
                if (clr_idx_r == LAST_IDX) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = CLEAR;
                end
            end
            RUN:     state_nx_s = RUN;
            default: state_nx_s = CLEAR;
        endcase
    end

    // State decode used by the datapath.
    always_comb begin
        run_s = 1'b0;
        clr_s = 1'b0;
        case (state_r)
            CLEAR:   clr_s = 1'b1;
            RUN:     run_s = 1'b1;
            default: clr_s = 1'b1;
        endcase
    end

    // Single array write port, shared by the clear engine and architectural writes.
    always_comb begin
        wr_ok_s     = run_s && we && (waddr != '0) && rf_in_range(32'(waddr), NREGS);
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = '0;
        if (!rst) begin
            mem_we_s = 1'b0;
        end else if (clr_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_idx_r;
        end else if (wr_ok_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = waddr;
            mem_wdata_s = wdata;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array update.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Combinational read lanes: x0, out-of-range and CLEAR read zero; optional write bypass.
    always_comb begin
        rdata = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (!run_s || (raddr[p*AW +: AW] == '0) || !rf_in_range(32'(raddr[p*AW +: AW]), NREGS)) begin
                rdata[p*XLEN +: XLEN] = '0;
            end else if ((BYPASS != 0) && we && (waddr == raddr[p*AW +: AW])) begin
                rdata[p*XLEN +: XLEN] = wdata;
            end else begin
                rdata[p*XLEN +: XLEN] = mem_r[raddr[p*AW +: AW]];
            end
        end
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .en       (run_s),
        .we       (we),
        .waddr    (waddr),
        .set_busy (set_busy),
        .set_addr (set_addr),
        .raddr    (raddr),
        .rbusy    (rbusy)
    );

    assign ready = ready_r;

endmodule
